match_ctl: RTL and testbench



---
 rtl/match_ctl_if.sv | 25 ++
 rtl/match_ctl.sv | 167 ++++++++++++++++
 tb/tb_match_ctl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/match_ctl_if.sv
// Signal bundle between the match sequencer and the ball/score datapath plus overlay.
// The master side is the sequencer; the slave side is the datapath/display.
interface match_ctl_if;
    logic       frame_tick;
    logic       start_btn;
    logic       pause_btn;
    logic [3:0] player_1_score;
    logic [3:0] player_2_score;
    logic       ball_rst;
    logic       ball_hold;
    logic [2:0] state;
    logic [1:0] countdown;
    logic       goal_flash;
    logic [1:0] winner;

    modport master (
        input  frame_tick, start_btn, pause_btn, player_1_score, player_2_score,
        output ball_rst, ball_hold, state, countdown, goal_flash, winner
    );

    modport slave (
        output frame_tick, start_btn, pause_btn, player_1_score, player_2_score,
        input  ball_rst, ball_hold, state, countdown, goal_flash, winner
    );
endinterface

// File: rtl/match_ctl.sv
// Air-hockey game-flow sequencer: attract, serve countdown, play, pause,
// post-goal pause and game over, with goal detection from the score inputs.
module match_ctl #(
    parameter int WIN_SCORE         = 7,
    parameter int FRAMES_PER_SEC    = 60,
    parameter int COUNTDOWN_SECS    = 3,
    parameter int GOAL_PAUSE_FRAMES = 90
) (
    input  logic        clk_in,
    input  logic        rst,
    match_ctl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        COUNTDOWN  = 3'd1,
        PLAY       = 3'd2,
        PAUSED     = 3'd3,
        GOAL_PAUSE = 3'd4,
        GAME_OVER  = 3'd5
    } state_t;

    // One shared frame counter serves both the countdown second and the goal pause.
    localparam int CNT_MAX = (FRAMES_PER_SEC - 1 > GOAL_PAUSE_FRAMES) ? FRAMES_PER_SEC - 1
                                                                      : GOAL_PAUSE_FRAMES;
    localparam int CNT_W = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SEC_LAST = CNT_W'(FRAMES_PER_SEC - 1);
    localparam logic [CNT_W-1:0] GP_LAST  = CNT_W'(GOAL_PAUSE_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [1:0]       CD_LOAD  = 2'(COUNTDOWN_SECS);
    localparam logic [3:0]       WIN      = 4'(WIN_SCORE);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       countdown_reg;
    logic             ball_rst_reg;
    logic             ball_hold_reg;
    logic             goal_flash_reg;
    logic [1:0]       winner_reg;
    logic             start_q_reg;
    logic             pause_q_reg;
    logic [3:0]       p1_prev_reg;
    logic [3:0]       p2_prev_reg;

    logic start_edge;
    logic pause_edge;
    logic goal_p1;
    logic goal_p2;
    logic win_p1;
    logic win_p2;

    assign start_edge = bus.start_btn & ~start_q_reg;
    assign pause_edge = bus.pause_btn & ~pause_q_reg;
    // Only increases count as goals, so a clear by ball_rst is never scored.
    assign goal_p1    = bus.player_1_score > p1_prev_reg;
    assign goal_p2    = bus.player_2_score > p2_prev_reg;
    assign win_p1     = goal_p1 && (bus.player_1_score >= WIN);
    assign win_p2     = goal_p2 && (bus.player_2_score >= WIN);

    always_ff @(posedge clk_in) begin
        start_q_reg <= bus.start_btn;
        pause_q_reg <= bus.pause_btn;
        p1_prev_reg <= bus.player_1_score;
        p2_prev_reg <= bus.player_2_score;

        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            countdown_reg  <= 2'd0;
            ball_rst_reg   <= 1'b1;
            ball_hold_reg  <= 1'b1;
            goal_flash_reg <= 1'b0;
            winner_reg     <= 2'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_edge) begin
                        state_reg     <= COUNTDOWN;
                        countdown_reg <= CD_LOAD;
                        cnt_reg       <= '0;
                        ball_rst_reg  <= 1'b0;
                    end
                end

                COUNTDOWN: begin
                    if (bus.frame_tick) begin
                        if (cnt_reg == SEC_LAST) begin
                            cnt_reg <= '0;
                            if (countdown_reg == 2'd1) begin
                                state_reg     <= PLAY;
                                countdown_reg <= 2'd0;
                                ball_hold_reg <= 1'b0;
                            end else begin
                                countdown_reg <= countdown_reg - 2'd1;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + CNT_ONE;
                        end
                    end
                end

                // PAUSED keeps watching goals: a score can land as hold asserts.
                PLAY, PAUSED: begin
                    if (goal_p1 || goal_p2) begin
                        ball_hold_reg <= 1'b1;
                        if (win_p1) begin
                            state_reg  <= GAME_OVER;
                            winner_reg <= 2'd1;
                        end else if (win_p2) begin
                            state_reg  <= GAME_OVER;
                            winner_reg <= 2'd2;
                        end else begin
                            state_reg      <= GOAL_PAUSE;
                            goal_flash_reg <= 1'b1;
                            cnt_reg        <= '0;
                        end
                    end else if (pause_edge) begin
                        if (state_reg == PLAY) begin
                            state_reg     <= PAUSED;
                            ball_hold_reg <= 1'b1;
                        end else begin
                            state_reg     <= PLAY;
                            ball_hold_reg <= 1'b0;
                        end
                    end
                end

                GOAL_PAUSE: begin
                    if (bus.frame_tick) begin
                        if (cnt_reg == GP_LAST) begin
                            state_reg      <= COUNTDOWN;
                            countdown_reg  <= CD_LOAD;
                            cnt_reg        <= '0;
                            goal_flash_reg <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_ONE;
                        end
                    end
                end

                GAME_OVER: begin
                    if (start_edge) begin
                        state_reg    <= IDLE;
                        ball_rst_reg <= 1'b1;
                        winner_reg   <= 2'd0;
                    end
                end

                default: begin
                    state_reg      <= IDLE;
                    cnt_reg        <= '0;
                    countdown_reg  <= 2'd0;
                    ball_rst_reg   <= 1'b1;
                    ball_hold_reg  <= 1'b1;
                    goal_flash_reg <= 1'b0;
                    winner_reg     <= 2'd0;
                end
            endcase
        end
    end

    assign bus.state      = state_reg;
    assign bus.countdown  = countdown_reg;
    assign bus.ball_rst   = ball_rst_reg;
    assign bus.ball_hold  = ball_hold_reg;
    assign bus.goal_flash = goal_flash_reg;
    assign bus.winner     = winner_reg;
endmodule

// File: tb/tb_match_ctl.sv
// Bench for match_ctl: directed walk through a full match plus random play,
// compared every cycle against a phase/tick-count model of the game rules.
module tb_match_ctl;
    localparam int WIN  = 7;
    localparam int FPS  = 60;
    localparam int SECS = 3;
    localparam int GPF  = 90;

    localparam int S_IDLE = 0, S_CD = 1, S_PLAY = 2, S_PAUSED = 3, S_GP = 4, S_OVER = 5;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;

    match_ctl_if bus();

    match_ctl #(
        .WIN_SCORE        (WIN),
        .FRAMES_PER_SEC   (FPS),
        .COUNTDOWN_SECS   (SECS),
        .GOAL_PAUSE_FRAMES(GPF)
    ) dut (
        .clk_in(clk_in),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    int vectors     = 0;
    int miscompares = 0;

    // Model: game phase, ticks elapsed inside the timed phase, winner, edge/goal history.
    int m_state  = S_IDLE;
    int m_ticks  = 0;
    int m_winner = 0;
    int m_p1_prev = 0, m_p2_prev = 0;
    bit m_start_q = 0, m_pause_q = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(bit r, bit ft, bit sb, bit pb, int s1, int s2);
        bit se, pe, g1, g2;
        if (r) begin
            m_state  = S_IDLE;
            m_ticks  = 0;
            m_winner = 0;
        end else begin
            se = sb && !m_start_q;
            pe = pb && !m_pause_q;
            g1 = s1 > m_p1_prev;
            g2 = s2 > m_p2_prev;
            case (m_state)
                S_IDLE: if (se) begin m_state = S_CD; m_ticks = 0; end
                S_CD: if (ft) begin
                    m_ticks++;
                    if (m_ticks == SECS * FPS) begin m_state = S_PLAY; m_ticks = 0; end
                end
                S_PLAY, S_PAUSED: begin
                    if (g1 || g2) begin
                        if (g1 && s1 >= WIN)      begin m_state = S_OVER; m_winner = 1; end
                        else if (g2 && s2 >= WIN) begin m_state = S_OVER; m_winner = 2; end
                        else                      begin m_state = S_GP;   m_ticks = 0;  end
                    end else if (pe) begin
                        m_state = (m_state == S_PLAY) ? S_PAUSED : S_PLAY;
                    end
                end
                S_GP: if (ft) begin
                    m_ticks++;
                    if (m_ticks == GPF) begin m_state = S_CD; m_ticks = 0; end
                end
                S_OVER: if (se) begin m_state = S_IDLE; m_winner = 0; end
                default: m_state = S_IDLE;
            endcase
        end
        m_start_q = sb;
        m_pause_q = pb;
        m_p1_prev = s1;
        m_p2_prev = s2;
    endtask

    // Advance one clock, step the model with the inputs seen at the edge, then compare.
    task automatic cycle();
        int exp_cd;
        @(posedge clk_in);
        model_step(rst, bus.frame_tick, bus.start_btn, bus.pause_btn,
                   int'(bus.player_1_score), int'(bus.player_2_score));
        #1;
        exp_cd = (m_state == S_CD) ? SECS - m_ticks / FPS : 0;
        check("state",      32'(bus.state),      32'(m_state));
        check("countdown",  32'(bus.countdown),  32'(exp_cd));
        check("ball_rst",   32'(bus.ball_rst),   32'(m_state == S_IDLE));
        check("ball_hold",  32'(bus.ball_hold),  32'(m_state != S_PLAY));
        check("goal_flash", 32'(bus.goal_flash), 32'(m_state == S_GP));
        check("winner",     32'(bus.winner),     32'(m_winner));
        $display("cyc t=%0t rst=%0b ft=%0b st=%0b pa=%0b s=%0d:%0d -> state=%0d cd=%0d win=%0d",
                 $time, rst, bus.frame_tick, bus.start_btn, bus.pause_btn,
                 bus.player_1_score, bus.player_2_score, bus.state, bus.countdown, bus.winner);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    int s1, s2;

    initial begin
        bus.frame_tick     = 1'b0;
        bus.start_btn      = 1'b0;
        bus.pause_btn      = 1'b0;
        bus.player_1_score = 4'd0;
        bus.player_2_score = 4'd0;
        rst = 1'b1;
        run(2);
        check("lit_rst_state", 32'(bus.state), 0);
        check("lit_rst_ball_rst", 32'(bus.ball_rst), 1);
        check("lit_rst_hold", 32'(bus.ball_hold), 1);
        rst = 1'b0;
        run(1);

        // Start and full countdown
        bus.start_btn = 1'b1; run(1);
        check("lit_start_state", 32'(bus.state), 1);
        check("lit_start_cd", 32'(bus.countdown), 3);
        bus.frame_tick = 1'b1; run(60);
        check("lit_cd_after60", 32'(bus.countdown), 2);
        run(120);
        check("lit_play_state", 32'(bus.state), 2);
        check("lit_play_hold", 32'(bus.ball_hold), 0);
        check("lit_play_ball_rst", 32'(bus.ball_rst), 0);

        // Goal and goal pause
        bus.frame_tick = 1'b0; bus.player_1_score = 4'd1; run(1);
        check("lit_goal_state", 32'(bus.state), 4);
        check("lit_goal_flash", 32'(bus.goal_flash), 1);
        check("lit_goal_hold", 32'(bus.ball_hold), 1);
        bus.frame_tick = 1'b1; run(89);
        check("lit_gp_89", 32'(bus.state), 4);
        run(1);
        check("lit_gp_done_state", 32'(bus.state), 1);
        check("lit_gp_done_cd", 32'(bus.countdown), 3);
        run(180);
        bus.frame_tick = 1'b0;

        // Pause toggling, then goal beating pause in the same cycle
        bus.pause_btn = 1'b1; run(1);
        check("lit_paused", 32'(bus.state), 3);
        check("lit_paused_hold", 32'(bus.ball_hold), 1);
        bus.pause_btn = 1'b0; run(1);
        bus.pause_btn = 1'b1; run(1);
        check("lit_unpaused", 32'(bus.state), 2);
        bus.pause_btn = 1'b0; run(1);
        bus.pause_btn = 1'b1; bus.player_1_score = 4'd2; run(1);
        check("lit_goal_over_pause", 32'(bus.state), 4);

        // Move to 6:3 while paused for the goal, then finish the match
        bus.pause_btn = 1'b0;
        bus.player_1_score = 4'd6; bus.player_2_score = 4'd3;
        bus.frame_tick = 1'b1; run(270);
        check("lit_back_to_play", 32'(bus.state), 2);
        bus.frame_tick = 1'b0;
        bus.player_2_score = 4'd4; run(1);
        check("lit_p2_goal", 32'(bus.state), 4);
        bus.frame_tick = 1'b1; run(270); bus.frame_tick = 1'b0;
        bus.player_1_score = 4'd7; run(1);
        check("lit_game_over", 32'(bus.state), 5);
        check("lit_winner", 32'(bus.winner), 1);
        run(3);
        bus.start_btn = 1'b0; run(1);
        bus.start_btn = 1'b1; run(1);
        check("lit_over_to_idle", 32'(bus.state), 0);
        check("lit_idle_ball_rst", 32'(bus.ball_rst), 1);
        check("lit_idle_winner", 32'(bus.winner), 0);
        bus.player_1_score = 4'd0; bus.player_2_score = 4'd0; run(5);
        check("lit_held_start", 32'(bus.state), 0);

        // Reset mid-countdown
        bus.start_btn = 1'b0; run(1);
        bus.start_btn = 1'b1; run(1);
        bus.frame_tick = 1'b1; run(60);
        check("lit_cd2_before_rst", 32'(bus.countdown), 2);
        rst = 1'b1; run(1);
        check("lit_midcd_rst_state", 32'(bus.state), 0);
        check("lit_midcd_rst_cd", 32'(bus.countdown), 0);
        check("lit_midcd_rst_ball_rst", 32'(bus.ball_rst), 1);
        rst = 1'b0; bus.frame_tick = 1'b0; bus.start_btn = 1'b0; run(1);

        // Score drop during play is not a goal
        bus.start_btn = 1'b1; run(1);
        bus.frame_tick = 1'b1; run(180); bus.frame_tick = 1'b0;
        bus.player_1_score = 4'd5; run(1);
        check("lit_goal5", 32'(bus.state), 4);
        bus.frame_tick = 1'b1; run(270); bus.frame_tick = 1'b0;
        bus.player_1_score = 4'd0; run(2);
        check("lit_drop_no_goal", 32'(bus.state), 2);

        // Random play
        s1 = 0; s2 = 0;
        for (int i = 0; i < 6000; i++) begin
            bus.frame_tick = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) bus.start_btn = ~bus.start_btn;
            if ($urandom_range(0, 19) == 0) bus.pause_btn = ~bus.pause_btn;
            rst = ($urandom_range(0, 1499) == 0);
            if (m_state == S_IDLE) begin
                s1 = 0; s2 = 0;
            end else if (m_state == S_PLAY || m_state == S_PAUSED) begin
                if ($urandom_range(0, 39) == 0 && s1 < 15) s1++;
                if ($urandom_range(0, 39) == 0 && s2 < 15) s2++;
                if ($urandom_range(0, 299) == 0) s1 = 0;
            end
            bus.player_1_score = 4'(s1);
            bus.player_2_score = 4'(s2);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
